// File: rtl/spi_slave_word.sv
// SPI slave with configurable word width and mode; SCK/SSEL/MOSI are oversampled in the clk domain.
// One-word TX holding register with valid/ready handshake, underrun fill and frame status pulses.
module spi_slave_word #(
    parameter int unsigned       WORD_W    = 16,
    parameter bit                CPOL      = 1'b0,
    parameter bit                CPHA      = 1'b0,
    parameter logic [WORD_W-1:0] FILL_WORD = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              mosi,
    input  logic              ssel,
    output logic              miso,
    output logic              miso_oe,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [WORD_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_underrun,
    output logic              frame_start,
    output logic              frame_end,
    output logic              partial_word
);

    localparam int unsigned     CW   = $clog2(WORD_W);
    localparam logic [CW-1:0]   LAST = CW'(WORD_W - 1);

    logic [2:0]        sck_sync;
    logic [2:0]        ssel_sync;
    logic [1:0]        mosi_sync;
    logic [CW-1:0]     bitcnt;
    // The oldest received bit leaves through rx_data, so the shifter is one bit short of a word.
    logic [WORD_W-2:0] rx_shift;
    logic [WORD_W-1:0] tx_shift;
    logic [WORD_W-1:0] hold;
    logic              hold_full;

    logic ssel_active;
    logic ssel_fall;
    logic ssel_rise;
    logic lead_edge;
    logic trail_edge;
    logic sample_edge;
    logic shift_edge;
    logic load;

    assign ssel_active = ~ssel_sync[1];
    assign ssel_fall   = ssel_sync[2] & ~ssel_sync[1];
    assign ssel_rise   = ~ssel_sync[2] & ssel_sync[1];
    assign lead_edge   = (sck_sync[2] == CPOL) && (sck_sync[1] != CPOL);
    assign trail_edge  = (sck_sync[2] != CPOL) && (sck_sync[1] == CPOL);
    assign sample_edge = ssel_active && (CPHA ? trail_edge : lead_edge);
    // frame_start wins over a shift edge landing in the same cycle.
    assign shift_edge  = ssel_active && !ssel_fall && (CPHA ? lead_edge : trail_edge);
    assign load        = (ssel_fall && !CPHA) || (shift_edge && (bitcnt == '0));

    assign miso     = tx_shift[WORD_W-1];
    assign miso_oe  = ssel_active;
    assign tx_ready = ~hold_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync     <= {3{CPOL}};
            ssel_sync    <= '1;
            mosi_sync    <= '0;
            bitcnt       <= '0;
            rx_shift     <= '0;
            tx_shift     <= '0;
            hold         <= '0;
            hold_full    <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            tx_underrun  <= 1'b0;
            frame_start  <= 1'b0;
            frame_end    <= 1'b0;
            partial_word <= 1'b0;
        end else begin
            sck_sync     <= {sck_sync[1:0], sck};
            ssel_sync    <= {ssel_sync[1:0], ssel};
            mosi_sync    <= {mosi_sync[0], mosi};
            rx_valid     <= 1'b0;
            tx_underrun  <= 1'b0;
            frame_start  <= ssel_fall;
            frame_end    <= ssel_rise;
            partial_word <= ssel_rise && (bitcnt != '0);

            if (!ssel_active) begin
                bitcnt <= '0;
            end else if (sample_edge) begin
                rx_shift <= {rx_shift[WORD_W-3:0], mosi_sync[1]};
                if (bitcnt == LAST) begin
                    bitcnt   <= '0;
                    rx_data  <= {rx_shift, mosi_sync[1]};
                    rx_valid <= 1'b1;
                end else begin
                    bitcnt <= bitcnt + 1'b1;
                end
            end

            if (load) begin
                if (hold_full) begin
                    tx_shift  <= hold;
                    hold_full <= 1'b0;
                end else if (tx_valid) begin
                    tx_shift <= tx_data;
                end else begin
                    tx_shift    <= FILL_WORD;
                    tx_underrun <= 1'b1;
                end
            end else begin
                if (shift_edge) begin
                    tx_shift <= {tx_shift[WORD_W-2:0], 1'b0};
                end
                if (tx_valid && !hold_full) begin
                    hold      <= tx_data;
                    hold_full <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_word.sv
// Bench for spi_slave_word: four instances (mode 0, mode 3, 8-bit mode 0, mode 1) driven by a
// bit-banged master; received words are checked against a scoreboard queue as rx_valid fires.
module tb_spi_slave_word;

    localparam int H = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        mosi;
    logic [3:0]  sck;
    logic [3:0]  ssel;
    logic [3:0]  tx_valid;
    logic [15:0] tx_data16;
    logic [7:0]  tx_data8;

    wire [3:0]  miso, miso_oe, rx_valid, tx_ready, tx_underrun, frame_start, frame_end, partial_word;
    wire [15:0] rx_data0, rx_data1, rx_data3;
    wire [7:0]  rx_data2;

    int errors = 0;
    int checks = 0;
    int rxv_cnt[4] = '{0, 0, 0, 0};
    int und_cnt[4] = '{0, 0, 0, 0};
    int fs_cnt[4]  = '{0, 0, 0, 0};
    int fe_cnt[4]  = '{0, 0, 0, 0};
    int pw_cnt[4]  = '{0, 0, 0, 0};

    typedef struct {
        int          inst;
        logic [15:0] data;
    } rx_exp_t;

    rx_exp_t     rx_q[$];
    rx_exp_t     mon_e;
    logic [15:0] miso_q[$];

    always #5 clk = ~clk;

    spi_slave_word #(.WORD_W(16), .CPOL(1'b0), .CPHA(1'b0)) u_m0 (
        .clk(clk), .rst(rst), .sck(sck[0]), .mosi(mosi), .ssel(ssel[0]),
        .miso(miso[0]), .miso_oe(miso_oe[0]), .rx_data(rx_data0), .rx_valid(rx_valid[0]),
        .tx_data(tx_data16), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
        .tx_underrun(tx_underrun[0]), .frame_start(frame_start[0]), .frame_end(frame_end[0]),
        .partial_word(partial_word[0]));

    spi_slave_word #(.WORD_W(16), .CPOL(1'b1), .CPHA(1'b1), .FILL_WORD(16'hF00D)) u_m3 (
        .clk(clk), .rst(rst), .sck(sck[1]), .mosi(mosi), .ssel(ssel[1]),
        .miso(miso[1]), .miso_oe(miso_oe[1]), .rx_data(rx_data1), .rx_valid(rx_valid[1]),
        .tx_data(tx_data16), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
        .tx_underrun(tx_underrun[1]), .frame_start(frame_start[1]), .frame_end(frame_end[1]),
        .partial_word(partial_word[1]));

    spi_slave_word #(.WORD_W(8), .CPOL(1'b0), .CPHA(1'b0)) u_w8 (
        .clk(clk), .rst(rst), .sck(sck[2]), .mosi(mosi), .ssel(ssel[2]),
        .miso(miso[2]), .miso_oe(miso_oe[2]), .rx_data(rx_data2), .rx_valid(rx_valid[2]),
        .tx_data(tx_data8), .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]),
        .tx_underrun(tx_underrun[2]), .frame_start(frame_start[2]), .frame_end(frame_end[2]),
        .partial_word(partial_word[2]));

    spi_slave_word #(.WORD_W(16), .CPOL(1'b0), .CPHA(1'b1)) u_m1 (
        .clk(clk), .rst(rst), .sck(sck[3]), .mosi(mosi), .ssel(ssel[3]),
        .miso(miso[3]), .miso_oe(miso_oe[3]), .rx_data(rx_data3), .rx_valid(rx_valid[3]),
        .tx_data(tx_data16), .tx_valid(tx_valid[3]), .tx_ready(tx_ready[3]),
        .tx_underrun(tx_underrun[3]), .frame_start(frame_start[3]), .frame_end(frame_end[3]),
        .partial_word(partial_word[3]));

    function automatic logic [15:0] rxd(input int i);
        case (i)
            0:       return rx_data0;
            1:       return rx_data1;
            2:       return {8'h00, rx_data2};
            default: return rx_data3;
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rx_valid[i]) begin
                rxv_cnt[i]++;
                checks++;
                if (rx_q.size() == 0) begin
                    errors++;
                    $display("FAIL rx_unexpected inst%0d: got %h, required no word", i, rxd(i));
                end else begin
                    mon_e = rx_q.pop_front();
                    if (mon_e.inst != i || rxd(i) !== mon_e.data) begin
                        errors++;
                        $display("FAIL rx_data inst%0d: got %h, required inst%0d %h",
                                 i, rxd(i), mon_e.inst, mon_e.data);
                    end
                end
            end
            if (tx_underrun[i]) und_cnt[i]++;
            if (frame_start[i]) fs_cnt[i]++;
            if (frame_end[i])   fe_cnt[i]++;
            if (partial_word[i]) begin
                pw_cnt[i]++;
                checks++;
                if (!frame_end[i]) begin
                    errors++;
                    $display("FAIL pw_with_fe inst%0d: frame_end=%b, required 1", i, frame_end[i]);
                end
            end
        end
    end

    task automatic expect_rx(input int i, input logic [15:0] d);
        rx_exp_t e;
        e.inst = i;
        e.data = d;
        rx_q.push_back(e);
    endtask

    task automatic tx_push(input int i, input logic [15:0] d);
        int n = 0;
        while (!tx_ready[i] && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!tx_ready[i]) begin
            errors++;
            $display("FAIL tx_ready_timeout inst%0d: tx_ready=%b, required 1", i, tx_ready[i]);
        end
        tx_data16   = d;
        tx_data8    = d[7:0];
        tx_valid[i] = 1'b1;
        @(negedge clk);
        tx_valid[i] = 1'b0;
    endtask

    // Master: drives nbits MSB-first of a w-bit word and captures miso on its sample edges.
    task automatic spi_bits(input int i, input bit cpol, input bit cpha, input int w,
                            input int nbits, input logic [15:0] wout, output logic [15:0] win);
        win = '0;
        for (int k = 0; k < nbits; k++) begin
            int b;
            b = w - 1 - k;
            if (!cpha) begin
                mosi = wout[b];
                repeat (H) @(negedge clk);
                sck[i] = ~cpol;
                win[b] = miso[i];
                repeat (H) @(negedge clk);
                sck[i] = cpol;
            end else begin
                sck[i] = ~cpol;
                mosi = wout[b];
                repeat (H) @(negedge clk);
                sck[i] = cpol;
                win[b] = miso[i];
                repeat (H) @(negedge clk);
            end
        end
    endtask

    task automatic check_miso_word(input string name, input logic [15:0] got);
        logic [15:0] exp;
        exp = miso_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: miso word %h, required %h", name, got, exp);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (rx_valid !== 4'h0)    begin errors++; $display("FAIL rst_rx_valid: %b, required 0000", rx_valid); end
        checks++; if (tx_ready !== 4'hF)    begin errors++; $display("FAIL rst_tx_ready: %b, required 1111", tx_ready); end
        checks++; if (miso !== 4'h0)        begin errors++; $display("FAIL rst_miso: %b, required 0000", miso); end
        checks++; if (miso_oe !== 4'h0)     begin errors++; $display("FAIL rst_miso_oe: %b, required 0000", miso_oe); end
        checks++; if (tx_underrun !== 4'h0) begin errors++; $display("FAIL rst_underrun: %b, required 0000", tx_underrun); end
        checks++; if ((frame_start | frame_end | partial_word) !== 4'h0) begin
            errors++; $display("FAIL rst_frame_pulses: fs=%b fe=%b pw=%b, required 0", frame_start, frame_end, partial_word);
        end
        checks++; if ({rx_data0, rx_data1, rx_data2, rx_data3} !== 56'h0) begin
            errors++; $display("FAIL rst_rx_data: %h %h %h %h, required 0", rx_data0, rx_data1, rx_data2, rx_data3);
        end
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (tx_ready !== 4'hF) begin errors++; $display("FAIL post_rst_tx_ready: %b, required 1111", tx_ready); end
        checks++; if (fs_cnt[0] + fs_cnt[1] + fs_cnt[2] + fs_cnt[3] != 0) begin
            errors++; $display("FAIL post_rst_frame_start: %0d pulses, required 0", fs_cnt[0] + fs_cnt[1] + fs_cnt[2] + fs_cnt[3]);
        end
    endtask

    task automatic test_mode0;
        logic [15:0] got;
        int u0, r0, f0, e0, p0;
        u0 = und_cnt[0]; r0 = rxv_cnt[0]; f0 = fs_cnt[0]; e0 = fe_cnt[0]; p0 = pw_cnt[0];
        tx_push(0, 16'h1234);
        checks++; if (tx_ready[0] !== 1'b0) begin errors++; $display("FAIL m0_hold_full: tx_ready=%b, required 0", tx_ready[0]); end
        miso_q.push_back(16'h1234);
        expect_rx(0, 16'hA5C3);
        ssel[0] = 1'b0;
        repeat (H) @(negedge clk);
        checks++; if (miso_oe[0] !== 1'b1) begin errors++; $display("FAIL m0_miso_oe: %b, required 1", miso_oe[0]); end
        checks++; if (tx_ready[0] !== 1'b1) begin errors++; $display("FAIL m0_hold_consumed: tx_ready=%b, required 1", tx_ready[0]); end
        // A spare word covers the LOAD on the closing trailing edge.
        tx_push(0, 16'hBEEF);
        repeat (H) @(negedge clk);
        spi_bits(0, 1'b0, 1'b0, 16, 16, 16'hA5C3, got);
        check_miso_word("m0_miso", got);
        repeat (H) @(negedge clk);
        ssel[0] = 1'b1;
        repeat (2 * H) @(negedge clk);
        checks++; if (und_cnt[0] - u0 != 0) begin errors++; $display("FAIL m0_underrun: %0d pulses, required 0", und_cnt[0] - u0); end
        checks++; if (rxv_cnt[0] - r0 != 1) begin errors++; $display("FAIL m0_rx_valid: %0d pulses, required 1", rxv_cnt[0] - r0); end
        checks++; if (fs_cnt[0] - f0 != 1 || fe_cnt[0] - e0 != 1) begin
            errors++; $display("FAIL m0_frame: fs=%0d fe=%0d, required 1 1", fs_cnt[0] - f0, fe_cnt[0] - e0);
        end
        checks++; if (pw_cnt[0] - p0 != 0) begin errors++; $display("FAIL m0_partial: %0d pulses, required 0", pw_cnt[0] - p0); end
        checks++; if (tx_ready[0] !== 1'b1 || miso_oe[0] !== 1'b0) begin
            errors++; $display("FAIL m0_end_state: tx_ready=%b miso_oe=%b, required 1 0", tx_ready[0], miso_oe[0]);
        end
    endtask

    task automatic test_mode3_multiword;
        logic [15:0] got;
        int u0, r0, p0;
        u0 = und_cnt[1]; r0 = rxv_cnt[1]; p0 = pw_cnt[1];
        tx_push(1, 16'h0001);
        miso_q.push_back(16'h0001);
        miso_q.push_back(16'h0002);
        miso_q.push_back(16'hF00D);
        expect_rx(1, 16'h1111);
        expect_rx(1, 16'h2222);
        expect_rx(1, 16'h3333);
        ssel[1] = 1'b0;
        repeat (H) @(negedge clk);
        fork
            spi_bits(1, 1'b1, 1'b1, 16, 16, 16'h1111, got);
            begin
                repeat (4 * H) @(negedge clk);
                tx_push(1, 16'h0002);
            end
        join
        check_miso_word("m3_word0", got);
        spi_bits(1, 1'b1, 1'b1, 16, 16, 16'h2222, got);
        check_miso_word("m3_word1", got);
        spi_bits(1, 1'b1, 1'b1, 16, 16, 16'h3333, got);
        check_miso_word("m3_word2_fill", got);
        repeat (H) @(negedge clk);
        ssel[1] = 1'b1;
        repeat (2 * H) @(negedge clk);
        checks++; if (und_cnt[1] - u0 != 1) begin errors++; $display("FAIL m3_underrun: %0d pulses, required 1", und_cnt[1] - u0); end
        checks++; if (rxv_cnt[1] - r0 != 3) begin errors++; $display("FAIL m3_rx_valid: %0d pulses, required 3", rxv_cnt[1] - r0); end
        checks++; if (pw_cnt[1] - p0 != 0) begin errors++; $display("FAIL m3_partial: %0d pulses, required 0", pw_cnt[1] - p0); end
    endtask

    task automatic test_bypass;
        logic [15:0] got;
        int u0, r0, f0;
        bit  saw_low;
        u0 = und_cnt[2]; r0 = rxv_cnt[2]; f0 = fs_cnt[2];
        saw_low = 1'b0;
        miso_q.push_back(16'h005A);
        expect_rx(2, 16'h00C6);
        @(negedge clk);
        ssel[2] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        // tx_valid is high only across the edge where the synchronised ssel fall triggers LOAD.
        tx_data8    = 8'h5A;
        tx_valid[2] = 1'b1;
        @(negedge clk);
        tx_valid[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (!tx_ready[2]) saw_low = 1'b1;
            @(negedge clk);
        end
        checks++; if (saw_low || tx_ready[2] !== 1'b1) begin errors++; $display("FAIL byp_tx_ready: dropped=%b, required stays 1", saw_low); end
        checks++; if (und_cnt[2] - u0 != 0) begin errors++; $display("FAIL byp_underrun: %0d pulses, required 0", und_cnt[2] - u0); end
        checks++; if (fs_cnt[2] - f0 != 1) begin errors++; $display("FAIL byp_frame_start: %0d pulses, required 1", fs_cnt[2] - f0); end
        repeat (H) @(negedge clk);
        spi_bits(2, 1'b0, 1'b0, 8, 8, 16'h00C6, got);
        check_miso_word("byp_miso", got);
        repeat (H) @(negedge clk);
        ssel[2] = 1'b1;
        repeat (2 * H) @(negedge clk);
        checks++; if (rxv_cnt[2] - r0 != 1) begin errors++; $display("FAIL byp_rx_valid: %0d pulses, required 1", rxv_cnt[2] - r0); end
    endtask

    task automatic test_abort;
        logic [15:0] got;
        int r0, e0, p0;
        r0 = rxv_cnt[0]; e0 = fe_cnt[0]; p0 = pw_cnt[0];
        @(negedge clk);
        ssel[0] = 1'b0;
        repeat (H) @(negedge clk);
        spi_bits(0, 1'b0, 1'b0, 16, 5, 16'hFFFF, got);
        repeat (H) @(negedge clk);
        ssel[0] = 1'b1;
        repeat (2 * H) @(negedge clk);
        checks++; if (fe_cnt[0] - e0 != 1) begin errors++; $display("FAIL abort_frame_end: %0d pulses, required 1", fe_cnt[0] - e0); end
        checks++; if (pw_cnt[0] - p0 != 1) begin errors++; $display("FAIL abort_partial: %0d pulses, required 1", pw_cnt[0] - p0); end
        checks++; if (rxv_cnt[0] - r0 != 0) begin errors++; $display("FAIL abort_rx_valid: %0d pulses, required 0", rxv_cnt[0] - r0); end
        r0 = rxv_cnt[0]; p0 = pw_cnt[0];
        miso_q.push_back(16'h0000);
        expect_rx(0, 16'hFFFF);
        ssel[0] = 1'b0;
        repeat (H) @(negedge clk);
        spi_bits(0, 1'b0, 1'b0, 16, 16, 16'hFFFF, got);
        check_miso_word("abort_next_miso_fill", got);
        repeat (H) @(negedge clk);
        ssel[0] = 1'b1;
        repeat (2 * H) @(negedge clk);
        checks++; if (rxv_cnt[0] - r0 != 1) begin errors++; $display("FAIL abort_next_rx_valid: %0d pulses, required 1", rxv_cnt[0] - r0); end
        checks++; if (pw_cnt[0] - p0 != 0) begin errors++; $display("FAIL abort_next_partial: %0d pulses, required 0", pw_cnt[0] - p0); end
    endtask

    task automatic test_reset_midword;
        logic [15:0] got;
        int r0, u0;
        tx_push(3, 16'hAAAA);
        ssel[3] = 1'b0;
        repeat (H) @(negedge clk);
        fork
            spi_bits(3, 1'b0, 1'b1, 16, 7, 16'h0F0F, got);
            begin
                repeat (2 * H) @(negedge clk);
                tx_push(3, 16'h5555);
            end
        join
        checks++; if (tx_ready[3] !== 1'b0 || miso_oe[3] !== 1'b1) begin
            errors++; $display("FAIL midrst_pre: tx_ready=%b miso_oe=%b, required 0 1", tx_ready[3], miso_oe[3]);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (tx_ready[3] !== 1'b1) begin errors++; $display("FAIL midrst_tx_ready: %b, required 1", tx_ready[3]); end
        checks++; if (miso[3] !== 1'b0 || miso_oe[3] !== 1'b0) begin
            errors++; $display("FAIL midrst_miso: miso=%b oe=%b, required 0 0", miso[3], miso_oe[3]);
        end
        checks++; if (rx_data3 !== 16'h0 || rx_valid[3] !== 1'b0 || tx_underrun[3] !== 1'b0) begin
            errors++; $display("FAIL midrst_rx: data=%h valid=%b und=%b, required 0000 0 0", rx_data3, rx_valid[3], tx_underrun[3]);
        end
        ssel[3] = 1'b1;
        sck[3]  = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        r0 = rxv_cnt[3]; u0 = und_cnt[3];
        tx_push(3, 16'h8001);
        miso_q.push_back(16'h8001);
        expect_rx(3, 16'h8001);
        ssel[3] = 1'b0;
        repeat (H) @(negedge clk);
        spi_bits(3, 1'b0, 1'b1, 16, 16, 16'h8001, got);
        check_miso_word("midrst_next_miso", got);
        repeat (H) @(negedge clk);
        ssel[3] = 1'b1;
        repeat (2 * H) @(negedge clk);
        checks++; if (rxv_cnt[3] - r0 != 1) begin errors++; $display("FAIL midrst_next_rx_valid: %0d pulses, required 1", rxv_cnt[3] - r0); end
        checks++; if (und_cnt[3] - u0 != 0) begin errors++; $display("FAIL midrst_next_underrun: %0d pulses, required 0", und_cnt[3] - u0); end
    endtask

    task automatic test_idle_sck;
        logic [15:0] got;
        logic        m;
        bit          oe_seen, miso_moved;
        int          r0, u0, f0;
        tx_push(0, 16'h3C3C);
        r0 = rxv_cnt[0]; u0 = und_cnt[0]; f0 = fs_cnt[0];
        m = miso[0];
        oe_seen = 1'b0;
        miso_moved = 1'b0;
        for (int k = 0; k < 20; k++) begin
            sck[0] = ~sck[0];
            mosi   = 1'($urandom_range(0, 1));
            repeat (3) @(negedge clk);
            if (miso_oe[0]) oe_seen = 1'b1;
            if (miso[0] !== m) miso_moved = 1'b1;
        end
        repeat (H) @(negedge clk);
        checks++; if (oe_seen) begin errors++; $display("FAIL idle_miso_oe: seen high, required 0"); end
        checks++; if (miso_moved) begin errors++; $display("FAIL idle_miso: changed from %b, required stable", m); end
        checks++; if (rxv_cnt[0] - r0 != 0 || und_cnt[0] - u0 != 0 || fs_cnt[0] - f0 != 0) begin
            errors++; $display("FAIL idle_pulses: rxv=%0d und=%0d fs=%0d, required 0 0 0", rxv_cnt[0] - r0, und_cnt[0] - u0, fs_cnt[0] - f0);
        end
        checks++; if (tx_ready[0] !== 1'b0) begin errors++; $display("FAIL idle_no_load: tx_ready=%b, required 0", tx_ready[0]); end
        r0 = rxv_cnt[0];
        miso_q.push_back(16'h3C3C);
        expect_rx(0, 16'h1357);
        ssel[0] = 1'b0;
        repeat (H) @(negedge clk);
        spi_bits(0, 1'b0, 1'b0, 16, 16, 16'h1357, got);
        check_miso_word("idle_next_miso", got);
        repeat (H) @(negedge clk);
        ssel[0] = 1'b1;
        repeat (2 * H) @(negedge clk);
        checks++; if (rxv_cnt[0] - r0 != 1) begin errors++; $display("FAIL idle_next_rx_valid: %0d pulses, required 1", rxv_cnt[0] - r0); end
    endtask

    initial begin
        rst       = 1'b1;
        mosi      = 1'b0;
        sck       = 4'b0010;
        ssel      = 4'b1111;
        tx_valid  = 4'b0000;
        tx_data16 = 16'h0;
        tx_data8  = 8'h0;
        test_reset();
        test_mode0();
        test_mode3_multiword();
        test_bypass();
        test_abort();
        test_reset_midword();
        test_idle_sck();
        checks++;
        if (rx_q.size() != 0) begin
            errors++;
            $display("FAIL rx_missing: %0d words outstanding, required 0", rx_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_slave_word.md
Name: spi_slave_word

Overview:
Parametrised SPI slave: configurable word width and SPI mode (CPOL/CPHA), with continuous multi-word frames. It has a one-word TX holding register with a valid/ready handshake, underrun fill, and frame/partial-word status pulses. It sits between the external SPI master pins and the motor-control command/status logic, running entirely in the system clock domain. SCK is oversampled, never used as a clock.

Parameters:
WORD_W, 16, bits per word (4..32)
CPOL, 0, SCK idle level
CPHA, 0, 0 = sample on leading edge; 1 = sample on trailing edge
FILL_WORD, 0, word shifted out when no TX word is available

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
sck  in  1  SPI clock from master (asynchronous)
mosi  in  1  SPI data in (asynchronous)
ssel  in  1  slave select, active low (asynchronous)
miso  out  1  SPI data out; MSB first
miso_oe  out  1  high while the synchronised ssel is active; external tri-state enable
rx_data  out  WORD_W  last complete received word
rx_valid  out  1  one-cycle pulse when rx_data updates
tx_data  in  WORD_W  next word to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  holding register empty
tx_underrun  out  1  one-cycle pulse when FILL_WORD is loaded instead of user data
frame_start  out  1  one-cycle pulse on ssel falling edge (synchronised)
frame_end  out  1  one-cycle pulse on ssel rising edge (synchronised)
partial_word  out  1  one-cycle pulse with frame_end when bitcnt != 0

Behaviour:
- Reset values: rx_data=0, all pulses=0, tx_ready=1, holding register empty, shift registers=0, bitcnt=0, miso=0, miso_oe=0. Synchroniser flops reset to the idle levels: sck=CPOL, ssel=1, mosi=0.
- Synchronisers: sck and ssel use 3-flop chains; edges are detected on stages [2:1]. mosi uses a 2-flop chain. Latency from pin to edge detection: 2–3 clk.
- Edge definition: leading edge = transition away from CPOL. Sample edge = leading when CPHA=0, trailing when CPHA=1. The shift edge is the other edge.
- Edges are ignored while ssel is inactive. bitcnt is held at 0 while ssel is inactive.
- Sample edge:
  - rx_shift <= {rx_shift[WORD_W-2:0], mosi_sync}.
  - bitcnt increments and wraps WORD_W-1 -> 0.
  - On the wrapping edge, rx_data <= the completed word and rx_valid pulses in the next clk (rx_data and rx_valid change together).
  - There is no RX backpressure; a new word overwrites rx_data.
- Shift edge: if bitcnt==0, perform a LOAD; otherwise tx_shift <= {tx_shift[WORD_W-2:0],0}.
- CPHA=0 only: a LOAD also occurs on frame_start, so the MSB is on miso before the first sample edge.
- LOAD source, in priority order:
  - Holding register full: use it; the register becomes empty and tx_ready returns to 1 next cycle.
  - Holding register empty and tx_valid=1 in the same cycle: use tx_data directly (bypass); this counts as the handshake.
  - Otherwise: use FILL_WORD and pulse tx_underrun.
- Handshake: accept when tx_valid && tx_ready. The holding register then becomes full and tx_ready=0 from the next cycle. A LOAD can never coincide with an accept into a full register.
- miso = tx_shift[WORD_W-1] (registered).
- Frame end (ssel rising):
  - frame_end pulses; partial_word pulses in the same cycle if bitcnt != 0.
  - A partial word is discarded: no rx_valid.
  - bitcnt clears. A full holding register is retained for the next frame.
- Simultaneous events: a sample edge coincident with frame_end is ignored. frame_start takes precedence over any shift edge in the same cycle.
- Reset mid-frame returns all state to reset values immediately. The first frame after reset release starts only on a fresh ssel falling edge.

Test Plan:
- Mode 0, WORD_W=16: master sends 0xA5C3, slave preloads 0x1234 -> miso bits 0x1234 MSB-first, rx_data=0xA5C3, rx_valid exactly once, tx_underrun=0.
- Mode 3 (CPOL=1, CPHA=1), three words per frame, tx words 0x0001/0x0002 queued in time -> miso carries 0x0001, 0x0002, then FILL_WORD with one tx_underrun pulse; three rx_valid pulses.
- WORD_W=8, CPHA=0: tx_valid asserted in the same cycle as a LOAD with the register empty -> bypass loads tx_data; tx_ready stays 1; no underrun.
- Abort after 5 of 16 bits -> frame_end and partial_word pulse together, no rx_valid, next frame starts at bitcnt 0 and receives 0xFFFF correctly.
- Assert rst mid-word in mode 1 -> all outputs at reset values next cycle; tx_ready=1; the following full frame transfers 0x8001 correctly.
- SCK toggling with ssel high -> no rx_valid, no LOAD, miso_oe=0, bitcnt stays 0.
